// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle for the iterative multiply/divide unit
//
// Signals:
//   start, op[1:0], srcA, srcB   request side, driven by the pipeline control (master)
//   busy, done, hi, lo           status and HI/LO results, driven by the unit (slave)
//   we_hi, we_lo, wdata          MTHI/MTLO writes, present only with MDU_HILO_WRITE_EN
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MDU_HILO_WRITE_EN
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wdata;
`endif

    modport master (
`ifdef MDU_HILO_WRITE_EN
        output we_hi, we_lo, wdata,
`endif
        output start, op, srcA, srcB,
        input  busy, done, hi, lo
    );

    modport slave (
`ifdef MDU_HILO_WRITE_EN
        input  we_hi, we_lo, wdata,
`endif
        input  start, op, srcA, srcB,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding results in HI/LO
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mul_div_unit_if.slave: start/op/srcA/srcB in, busy/done/hi/lo out
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. One shift step per cycle; done pulses
// WIDTH+1 edges after the edge that accepted start.
// Optional feature macro: MDU_HILO_WRITE_EN (adds we_hi/we_lo/wdata MTHI/MTLO writes).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [1:0]       op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] acc_hi_q;   // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_q;   // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] opb_q;      // |multiplicand| or |divisor|
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    assign a_neg  = bus.op[0] & bus.srcA[WIDTH-1];
    assign b_neg  = bus.op[0] & bus.srcB[WIDTH-1];
    // Magnitude of 0x80..0 wraps to itself, which is the correct unsigned magnitude.
    assign a_mag  = a_neg ? -bus.srcA : bus.srcA;
    assign b_mag  = b_neg ? -bus.srcB : bus.srcB;

    // Multiply step: conditional add, then shift the 2W+1-bit value right by one.
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : {WIDTH{1'b0}})};

    // Restoring divide step. When the subtraction succeeds the difference is below
    // the divisor, so its low WIDTH bits are exact.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;
    assign div_ge    = (div_shift >= {1'b0, opb_q});

    // Sign correction applied on the SIGN -> DONE edge.
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    always_comb begin
        res_hi = acc_hi_q;
        res_lo = acc_lo_q;
        case (op_q)
            2'b01: if (sign_a_q ^ sign_b_q) {res_hi, res_lo} = -{acc_hi_q, acc_lo_q};
            2'b11: begin
                if (sign_a_q ^ sign_b_q) res_lo = -acc_lo_q;
                if (sign_a_q)            res_hi = -acc_hi_q;
            end
            default: ;
        endcase
        // Divide by zero: remainder already equals the dividend after sign
        // correction; the quotient is forced to all ones regardless of signs.
        if (op_q[1] && b_zero_q) res_lo = {WIDTH{1'b1}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q  <= S_CALC;
                        busy_q   <= 1'b1;
                        count_q  <= '0;
                        op_q     <= bus.op;
                        sign_a_q <= a_neg;
                        sign_b_q <= b_neg;
                        b_zero_q <= (bus.srcB == '0);
                        acc_hi_q <= '0;
                        acc_lo_q <= a_mag;
                        opb_q    <= b_mag;
                    end else begin
                        state_q  <= S_IDLE;
                    end
`ifdef MDU_HILO_WRITE_EN
                    if (bus.we_hi) hi_q <= bus.wdata;
                    if (bus.we_lo) lo_q <= bus.wdata;
`endif
                end
                S_CALC: begin
                    count_q <= count_q + CW'(1);
                    if (op_q[1]) begin
                        if (div_ge) begin
                            acc_hi_q <= div_diff;
                            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_q <= div_shift[WIDTH-1:0];
                            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
                    end
                    if (count_q == CW'(WIDTH - 1)) state_q <= S_SIGN;
                end
                S_SIGN: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit (vectors, random, corner sequences)
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) bus ();
    mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: {hi, lo} straight from arithmetic definitions.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            2'b00: p = {32'd0, a} * {32'd0, b};
            2'b01: p = sa * sb;
            2'b10: if (b == 0) p = {a, 32'hFFFFFFFF}; else p = {a % b, a / b};
            default: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Drives a request now, lets the next rising edge accept it, scrambles the
    // inputs, and returns the number of edges until done is seen (100 = timeout).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.srcA  = $urandom;
        bus.srcB  = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.done && lat < 100);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, pulses, first;
        logic [63:0] held, exp;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4] = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srcA  = '0;
        bus.srcB  = '0;
`ifdef MDU_HILO_WRITE_EN
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        bus.wdata = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors; even entries leave an idle cycle, odd ones chain from DONE.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d hi/lo", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
            check($sformatf("vec%0d busy at done", i), {63'd0, bus.busy}, 64'd0);
            if (i % 2 == 0) begin
                held = {bus.hi, bus.lo};
                repeat (2) @(posedge clk);
                #1;
                check($sformatf("vec%0d done one cycle", i), {63'd0, bus.done}, 64'd0);
                check($sformatf("vec%0d hold in idle", i), {bus.hi, bus.lo}, held);
                @(negedge clk);
            end
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = pick();
            rb  = pick();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(rop, ra, rb, lat);
            exp = ref_model(rop, ra, rb);
            check($sformatf("rand%0d op%0d %h,%h latency", i, rop, ra, rb), 64'(lat), 64'd33);
            check($sformatf("rand%0d op%0d %h,%h hi/lo", i, rop, ra, rb), {bus.hi, bus.lo}, exp);
        end

        // start pulsed during CALC is ignored: exactly one done, at edge 33.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.srcA = 32'd1000; bus.srcB = 32'd33;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("calc busy", {63'd0, bus.busy}, 64'd1);
        pulses = 0;
        first  = 0;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk);
            #1;
            if (e == 5) begin
                bus.start = 1'b1; bus.op = 2'b00; bus.srcA = 32'd5; bus.srcB = 32'd6;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
        check("ignored start pulses", 64'(pulses), 64'd1);
        check("ignored start edge", 64'(first), 64'd33);
        check("ignored start result", {bus.hi, bus.lo}, {32'd10, 32'd30});

        // start held through DONE: second op begins from DONE, done 33 edges later.
        @(negedge clk);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        check("b2b first latency", 64'(lat), 64'd33);
        run_op(2'b11, 32'd100, 32'hFFFFFFF9, lat);
        check("b2b second latency", 64'(lat), 64'd33);
        check("b2b second hi/lo", {bus.hi, bus.lo}, {32'd2, 32'hFFFFFFF2});

        // Reset at cycle 10 of CALC aborts at once; no done afterwards.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.srcA = 32'd9; bus.srcB = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("abort hi/lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) pulses++;
        end
        check("no done after abort", 64'(pulses), 64'd0);
        @(negedge clk);
        run_op(2'b10, 32'd100, 32'd7, lat);
        check("post-reset latency", 64'(lat), 64'd33);
        check("post-reset hi/lo", {bus.hi, bus.lo}, {32'd2, 32'd14});

`ifdef MDU_HILO_WRITE_EN
        // MTHI/MTLO: idle write, ignored while busy, coincident with start.
        @(negedge clk);
        bus.we_hi = 1'b1; bus.wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.we_hi = 1'b0;
        check("we_hi idle", {bus.hi, bus.lo}, {32'hCAFEF00D, 32'd14});
        bus.start = 1'b1; bus.op = 2'b00; bus.srcA = 32'd3; bus.srcB = 32'd4;
        bus.we_lo = 1'b1; bus.wdata = 32'h12345678;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wdata = 32'hDEADBEEF;
        check("we_lo with start", {bus.hi, bus.lo}, {32'hCAFEF00D, 32'h12345678});
        @(posedge clk);
        #1;
        bus.we_lo = 1'b0;
        check("we_lo while busy", {bus.hi, bus.lo}, {32'hCAFEF00D, 32'h12345678});
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("write-mode latency", 64'(lat), 64'd33);
        check("write-mode result", {bus.hi, bus.lo}, {32'd0, 32'd12});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
